uart_frame_sender: RTL
======================

Name: uart_frame_sender

Overview:
- Downstream consumer of `circular_shift_register`. It takes a snapshot of the flat `WIDTH*SIZE` register bus and serializes it on one UART TX line.
- Frame format: word 0 first, 8N1-style per word (start bit, WIDTH data bits LSB first, one stop bit), back-to-back.
- Used to stream the rotating register contents off-chip to the Basys3 host, one burst per `start` request.

Parameters:
- WIDTH, 8, bits per word; also the number of data bits per UART frame.
- SIZE, 16, number of words per burst; word k = `data_in[k*WIDTH +: WIDTH]`.
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Legal range is ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  burst request; sampled only while idle.
- data_in  input  WIDTH*SIZE  flat word array, typically `reg_out` of the shift register.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse at burst completion.
- word_idx  output  $clog2(SIZE) (min 1)  index of the word currently on the line; 0 when idle.

Behaviour:
- One clock; reset is asynchronous and active-low, ports `clk` and `rst_n`.
- Reset values (applied immediately on `rst_n` low, independent of clk): tx=1, busy=0, done=0, word_idx=0, state=IDLE, all counters 0.
- States: IDLE, START_BIT, DATA_BITS, STOP_BIT.
- IDLE:
  - tx=1, busy=0.
  - If start=1 at posedge t: latch all of data_in into an internal shadow register, go to START_BIT, and set busy=1, tx=0 after edge t.
  - start=0 stays in IDLE.
- Later data_in changes have no effect until the next accepted start.
- Bit timing, with baud counter 0..CLKS_PER_BIT-1 and n = CLKS_PER_BIT:
  - Start bit occupies edges t..t+n.
  - Data bit i (LSB first) occupies edges t+n*(1+i) .. t+n*(2+i).
  - Stop bit (tx=1) occupies edges t+n*(WIDTH+1) .. t+n*(WIDTH+2).
- Frame length is n*(WIDTH+2) cycles.
- After the stop bit of word k < SIZE-1:
  - Go directly to START_BIT for word k+1, with no idle gap.
  - word_idx increments at that edge.
- After the stop bit of word SIZE-1, i.e. at edge t + SIZE*n*(WIDTH+2):
  - Return to IDLE with tx=1, busy=0, word_idx=0.
  - done=1 for exactly that one cycle.
- start=1 while busy=1 is ignored. It is not queued and has no effect on the burst in progress.
- start=1 during the done cycle is accepted, because busy=0. The next burst's start bit begins after that edge.
- tx is driven from a register and is glitch-free, with no combinational path from inputs.
- Reset asserted mid-burst aborts immediately: tx=1, busy=0, no done pulse. After reset release the block waits for a new start.
- Counters wrap exactly; there are no off-by-one extra cycles per bit, per frame, or per burst.

Test Plan:
Bench uses WIDTH=8, SIZE=4, CLKS_PER_BIT=4 (frame = 40 cycles, burst = 160 cycles).
- Reset check: hold rst_n=0 for 3 cycles, then release. Required: tx=1, busy=0, done=0, word_idx=0, and tx stays 1 for 20 idle cycles with start=0.
- Single burst: data_in=32'h44_33_22_11, pulse start for 1 cycle.
  - Sample tx mid-bit.
  - Required serial sequence per word: 0, data LSB first, 1. Word 0 = 8'h11 gives bits 0,1,0,0,0,1,0,0,0,1; then words 22, 33, 44.
  - busy=1 for exactly 160 cycles, done a single pulse on cycle 160, word_idx steps 0→1→2→3→0.
- Snapshot isolation: start a burst with 32'hA5A5A5A5, then change data_in to 32'h0 on the next cycle. Required: all four decoded bytes = A5.
- Start while busy: pulse start at cycles 10, 50 and 150 of a burst. Required: burst still ends at cycle 160 with exactly one done, and no second burst begins.
- Back-to-back bursts: assert start during the done cycle. Required: a new start bit at the next edge, and tx is never low longer than one bit period outside frame boundaries.
- Mid-burst reset: assert rst_n=0 at cycle 70 of a burst. Required: tx=1 and busy=0 within the same cycle (asynchronous), no done pulse. A subsequent start gives a clean full 160-cycle burst.
- Integration: connect to `circular_shift_register` (WIDTH=8, SIZE=4) `reg_out` and issue start on two consecutive bursts. Required: the decoded byte vectors differ by one word rotation.

Source files
------------

// File: rtl/uart_frame_sender.sv
// ============================================================================
// Module   : uart_frame_sender
// Purpose  : Snapshots a flat WIDTH*SIZE word bus on start and streams it out
//            as back-to-back 8N1-style UART frames, word 0 first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_frame_sender #(
    parameter int WIDTH        = 8,
    parameter int SIZE         = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [WIDTH*SIZE-1:0]               data_in,
    output logic                                tx,
    output logic                                busy,
    output logic                                done,
    output logic [((SIZE > 1) ? $clog2(SIZE) : 1)-1:0] word_idx
);

    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(SIZE - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   baud_cnt;
    logic [CNT_W-1:0]   baud_cnt_next;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_cnt_next;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_next;
    logic               tx_reg;
    logic               tx_next;
    logic               busy_reg;
    logic               busy_next;
    logic               done_reg;
    logic               done_next;
    logic               load_shadow;
    logic               baud_end;
    logic [WIDTH-1:0]   cur_word;

    logic [WIDTH-1:0]   shadow [SIZE];

    // Snapshot of the input bus, frozen for the whole burst.
    for (genvar k = 0; k < SIZE; k++) begin : g_shadow
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow[k] <= '0;
            end else if (load_shadow) begin
                shadow[k] <= data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    assign cur_word = shadow[idx];
    assign baud_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            idx      <= '0;
            tx_reg   <= 1'b1;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_cnt  <= bit_cnt_next;
            idx      <= idx_next;
            tx_reg   <= tx_next;
            busy_reg <= busy_next;
            done_reg <= done_next;
        end
    end

    // Outputs are computed one edge ahead so every port is a flop output.
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt;
        bit_cnt_next  = bit_cnt;
        idx_next      = idx;
        tx_next       = tx_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        load_shadow   = 1'b0;

        case (state)
            IDLE: begin
                tx_next       = 1'b1;
                busy_next     = 1'b0;
                idx_next      = '0;
                baud_cnt_next = '0;
                bit_cnt_next  = '0;
                if (start) begin
                    load_shadow = 1'b1;
                    state_next  = START_BIT;
                    tx_next     = 1'b0;
                    busy_next   = 1'b1;
                end
            end

            START_BIT: begin
                if (baud_end) begin
                    baud_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = DATA_BITS;
                    tx_next       = cur_word[0];
                end else begin
                    baud_cnt_next = baud_cnt + CNT_W'(1);
                end
            end

            DATA_BITS: begin
                if (baud_end) begin
                    baud_cnt_next = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_next = STOP_BIT;
                        tx_next    = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_W'(1);
                        tx_next      = cur_word[bit_cnt_next];
                    end
                end else begin
                    baud_cnt_next = baud_cnt + CNT_W'(1);
                end
            end

            STOP_BIT: begin
                if (baud_end) begin
                    baud_cnt_next = '0;
                    if (idx == WORD_LAST) begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        idx_next   = '0;
                    end else begin
                        idx_next   = idx + IDX_W'(1);
                        state_next = START_BIT;
                        tx_next    = 1'b0;
                    end
                end else begin
                    baud_cnt_next = baud_cnt + CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign tx       = tx_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign word_idx = idx;

endmodule

`default_nettype wire
